// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Byte-serial front end for an external 8-bit combinational ALU. A command
//   is an opcode beat, then an A beat, then a B beat. The A beat is skipped
//   when USE_ACC is set, and the B beat is skipped for unary opcodes.
//   Operands and the opcode are held in registers that drive the ALU. The
//   ALU result is captured after one settle cycle and offered downstream.
//   An accumulator keeps the last result so that chained operations can
//   reuse it as operand A.
//
//   Opcode beat layout: in_data[OP_W-1:0] = opcode, in_data[OP_W] = USE_ACC,
//   and the remaining upper bits are ignored.
//
//   Handshake: a beat or a result transfers on a rising clk edge where
//   valid && ready are both high. Ready never depends combinationally on
//   valid. A result is held stable while out_valid && !out_ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command/operand beat handshake
//   in_data               command/operand byte
//   alu_a, alu_b, alu_op  registered operands/opcode to the ALU
//   alu_y                 combinational ALU result
//   out_valid/out_ready   result handshake
//   out_data              registered result
//   out_zero, out_neg     result flags, present only with ALU_SEQ_FLAGS_EN
//   dbg_state             FSM state (0 GET_OP, 1 GET_A, 2 GET_B, 3 EXEC,
//                         4 RESULT)
//   dbg_acc               accumulator contents
//
// Build option: define ALU_SEQ_FLAGS_EN to add the out_zero/out_neg flags.
// -----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int unsigned     DATA_W      = 8,
   parameter int unsigned     OP_W        = 4,
   parameter logic [OP_W-1:0] UNARY_FIRST = 4'b0101
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef ALU_SEQ_FLAGS_EN
   output logic              out_zero,
   output logic              out_neg,
`endif
   output logic [2:0]        dbg_state,
   output logic [DATA_W-1:0] dbg_acc
);

   typedef enum logic [2:0] {
      GET_OP = 3'd0,
      GET_A  = 3'd1,
      GET_B  = 3'd2,
      EXEC   = 3'd3,
      RESULT = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [OP_W-1:0]   r_alu_op;
   logic [DATA_W-1:0] r_acc;
`ifdef ALU_SEQ_FLAGS_EN
   logic              r_out_zero;
   logic              r_out_neg;
`endif

   logic w_accept;
   logic w_use_acc;
   logic w_new_op_unary;
   logic w_cur_op_unary;
   logic w_unused_hi;

   assign w_accept       = in_valid && r_in_ready;
   assign w_use_acc      = in_data[OP_W];
   assign w_new_op_unary = (in_data[OP_W-1:0] >= UNARY_FIRST);
   assign w_cur_op_unary = (r_alu_op >= UNARY_FIRST);
   // Upper opcode-beat bits carry no meaning.
   assign w_unused_hi    = ^in_data[DATA_W-1:OP_W+1];

   // Single FSM; in_ready is registered and cleared on every transition
   // into EXEC, so it is low for the whole of EXEC and RESULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= GET_OP;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_acc       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         r_out_zero  <= 1'b1;
         r_out_neg   <= 1'b0;
`endif
      end else begin
         case (r_state)
            GET_OP: begin
               if (w_accept) begin
                  r_alu_op <= in_data[OP_W-1:0];
                  if (w_use_acc) begin
                     r_alu_a <= r_acc;
                     if (w_new_op_unary) begin
                        r_state    <= EXEC;
                        r_in_ready <= 1'b0;
                     end else begin
                        r_state <= GET_B;
                     end
                  end else begin
                     r_state <= GET_A;
                  end
               end
            end
            GET_A: begin
               if (w_accept) begin
                  r_alu_a <= in_data;
                  if (w_cur_op_unary) begin
                     r_state    <= EXEC;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_state <= GET_B;
                  end
               end
            end
            GET_B: begin
               if (w_accept) begin
                  r_alu_b    <= in_data;
                  r_state    <= EXEC;
                  r_in_ready <= 1'b0;
               end
            end
            EXEC: begin
               // Operand registers have been stable for a full cycle.
               r_out_data  <= alu_y;
               r_acc       <= alu_y;
               r_out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
               r_out_zero  <= (alu_y == '0);
               r_out_neg   <= alu_y[DATA_W-1];
`endif
               r_state     <= RESULT;
            end
            RESULT: begin
               // in_ready re-opens only after the result leaves, so the
               // next command starts the cycle after the handshake.
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= GET_OP;
               end
            end
            default: begin
               r_state     <= GET_OP;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
`ifdef ALU_SEQ_FLAGS_EN
   assign out_zero  = r_out_zero;
   assign out_neg   = r_out_neg;
`endif
   assign dbg_state = r_state;
   assign dbg_acc   = r_acc;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer. Provides a behavioural ALU on alu_y, drives
//   byte commands, and checks results through an expected-value queue plus
//   direct checks on the multi-cycle corner cases.
//   ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, 7 SHL,
//   8 ROL, 9 SHR, A ROR, B INV, C-F -> 0.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int W = 8;

   localparam logic [2:0] S_GET_OP = 3'd0;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef ALU_SEQ_FLAGS_EN
   logic         out_zero;
   logic         out_neg;
`endif
   logic [2:0]   dbg_state;
   logic [W-1:0] dbg_acc;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   alu_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_y     (alu_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef ALU_SEQ_FLAGS_EN
      .out_zero  (out_zero),
      .out_neg   (out_neg),
`endif
      .dbg_state (dbg_state),
      .dbg_acc   (dbg_acc)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ALU ----------------
   function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         4'h5:    return a + 8'd1;
         4'h6:    return a - 8'd1;
         4'h7:    return a << 1;
         4'h8:    return {a[W-2:0], a[W-1]};
         4'h9:    return a >> 1;
         4'hA:    return {a[0], a[W-1:1]};
         4'hB:    return ~a;
         default: return '0;
      endcase
   endfunction

   always_comb alu_y = alu_f(alu_op, alu_a, alu_b);

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: a result transfers on the next rising edge whenever
   // out_valid && out_ready hold at the falling edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("sb_out_data", {24'd0, out_data}, {24'd0, e});
`ifdef ALU_SEQ_FLAGS_EN
            check("sb_out_zero", {31'd0, out_zero}, {31'd0, (e == '0)});
            check("sb_out_neg", {31'd0, out_neg}, {31'd0, e[W-1]});
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [W-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("beat_accept_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("result_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   typedef struct {
      logic [W-1:0] b0;
      logic [W-1:0] b1;
      logic [W-1:0] b2;
      int           n;
      logic [W-1:0] exp;
   } vec_t;

   task automatic send_cmd(input vec_t v);
      if (v.n == 1) exp_q.push_back(v.exp);
      send_beat(v.b0);
      if (v.n >= 2) begin
         if (v.n == 2) exp_q.push_back(v.exp);
         send_beat(v.b1);
      end
      if (v.n == 3) begin
         exp_q.push_back(v.exp);
         send_beat(v.b2);
      end
   endtask

   vec_t tbl[11];

   // ---------------- test ----------------
   initial begin
      tbl[0]  = '{8'h10, 8'h02, 8'h00, 2, 8'h0A}; // ADD with acc 0x08
      tbl[1]  = '{8'h1B, 8'h00, 8'h00, 1, 8'hF5}; // INV of acc 0x0A
      tbl[2]  = '{8'h01, 8'h03, 8'h05, 3, 8'hFE}; // SUB wraps
      tbl[3]  = '{8'h03, 8'hA0, 8'h05, 3, 8'hA5}; // OR
      tbl[4]  = '{8'h02, 8'hF0, 8'h3C, 3, 8'h30}; // AND
      tbl[5]  = '{8'h05, 8'hFF, 8'h00, 2, 8'h00}; // INC wraps
      tbl[6]  = '{8'h06, 8'h00, 8'h00, 2, 8'hFF}; // DEC wraps
      tbl[7]  = '{8'h0C, 8'h55, 8'h00, 2, 8'h00}; // reserved opcode
      tbl[8]  = '{8'h00, 8'hFF, 8'h01, 3, 8'h00}; // ADD wraps to zero
      tbl[9]  = '{8'h1F, 8'h00, 8'h00, 1, 8'h00}; // reserved, acc path
      tbl[10] = '{8'hE4, 8'h0F, 8'h33, 3, 8'h3C}; // XOR, top bits ignored

      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset values (reset still asserted)
      check("rst_state", {29'd0, dbg_state}, {29'd0, S_GET_OP});
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_alu_a", {24'd0, alu_a}, 32'd0);
      check("rst_alu_b", {24'd0, alu_b}, 32'd0);
      check("rst_alu_op", {28'd0, alu_op}, 32'd0);
      check("rst_acc", {24'd0, dbg_acc}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("rst_out_zero", {31'd0, out_zero}, 32'd1);
      check("rst_out_neg", {31'd0, out_neg}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD latency: last beat accepted at edge k, result visible after k+1
      send_beat(8'h00);
      send_beat(8'h05);
      exp_q.push_back(8'h08);
      send_beat(8'h03);
      check("lat_k_out_valid", {31'd0, out_valid}, 32'd0);
      check("lat_k_state", {29'd0, dbg_state}, {29'd0, S_EXEC});
      check("lat_k_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("lat_k1_out_valid", {31'd0, out_valid}, 32'd1);
      check("lat_k1_out_data", {24'd0, out_data}, 32'h08);
      check("lat_k1_alu_op", {28'd0, alu_op}, 32'd0);
      check("lat_k1_acc", {24'd0, dbg_acc}, 32'h08);
      wait_result();
      check("add_back_to_get_op", {29'd0, dbg_state}, {29'd0, S_GET_OP});

      // Table-driven commands, results through the scoreboard
      for (int i = 0; i < 11; i++) begin
         send_cmd(tbl[i]);
         wait_result();
         check($sformatf("tbl%0d_acc", i), {24'd0, dbg_acc}, {24'd0, tbl[i].exp});
      end
      check("chain_alu_b_last", {24'd0, alu_b}, 32'h33);

      // Unary skip: ROL takes only opcode + A, alu_b keeps 0x33
      send_beat(8'h08);
      exp_q.push_back(8'h03);
      send_beat(8'h81);
      check("unary_in_ready", {31'd0, in_ready}, 32'd0);
      check("unary_alu_b", {24'd0, alu_b}, 32'h33);
      check("unary_alu_op", {28'd0, alu_op}, 32'h8);
      wait_result();

      // Backpressure: result held, beats ignored
      out_ready = 1'b0;
      send_beat(8'h00);
      send_beat(8'h05);
      exp_q.push_back(8'h08);
      send_beat(8'h03);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_data", {24'd0, out_data}, 32'h08);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_state", {29'd0, dbg_state}, {29'd0, S_RESULT});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_state", {29'd0, dbg_state}, {29'd0, S_GET_OP});
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      check("bp_alu_a_kept", {24'd0, alu_a}, 32'h05);
      check("bp_alu_b_kept", {24'd0, alu_b}, 32'h03);
      check("bp_queue_empty", exp_q.size(), 32'd0);

      // Reset in the middle of a command
      send_beat(8'h00);
      send_beat(8'h22);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("mid_rst_state", {29'd0, dbg_state}, {29'd0, S_GET_OP});
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_acc", {24'd0, dbg_acc}, 32'd0);
      check("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      send_cmd('{8'h04, 8'h0F, 8'hF0, 3, 8'hFF});
      wait_result();
      check("post_rst_acc", {24'd0, dbg_acc}, 32'hFF);

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 32'd0);
      check("final_out_valid", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
